// File: rtl/imm_gen_stage.sv
// ---------------------------------------------------------------------------------------------
// imm_gen_stage
//
// Decodes the immediate field of a 32-bit RISC-V instruction word according to an externally
// supplied format select. The result goes through a two-entry valid/ready pipeline stage made
// of an output register and a skid register.
//
// The immediate is decoded combinationally on the input side, so both entries hold final
// values. in_ready and out_valid come only from the state register. Neither has a
// combinational path from out_ready or in_valid.
//
// Parameters
//   XLEN   datapath width (32 or 64)
//   TAG_W  width of the sideband tag carried unchanged with each beat
//
// Ports
//   clk        clock, all state changes on the rising edge
//   rst_n      synchronous active-low reset; has priority over flush and accept
//   flush      synchronous discard of all held beats; has priority over accept
//   in_valid   upstream beat valid
//   in_ready   stage can take a beat (low only when the skid entry is occupied)
//   in_inst    raw instruction word
//   in_fmt     format: 0=I 1=S 2=B 3=U 4=J 5=ZIMM 6=SHAMT 7=NONE
//   in_tag     sideband tag
//   out_valid  output beat valid
//   out_ready  downstream accepts the output beat
//   out_imm    decoded immediate, XLEN bits
//   out_tag    tag of the output beat
// ---------------------------------------------------------------------------------------------
module imm_gen_stage #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned TAG_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_inst,
    input  logic [2:0]       in_fmt,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_imm,
    output logic [TAG_W-1:0] out_tag
);

    localparam logic [2:0] FmtI     = 3'd0;
    localparam logic [2:0] FmtS     = 3'd1;
    localparam logic [2:0] FmtB     = 3'd2;
    localparam logic [2:0] FmtU     = 3'd3;
    localparam logic [2:0] FmtJ     = 3'd4;
    localparam logic [2:0] FmtZimm  = 3'd5;
    localparam logic [2:0] FmtShamt = 3'd6;

    // EMPTY: nothing held. ONE: output entry valid. FULL: output and skid entries valid.
    typedef enum logic [1:0] {
        StEmpty,
        StOne,
        StFull
    } state_e;

    state_e           state_q, state_d;
    logic [XLEN-1:0]  out_imm_q, out_imm_d;
    logic [TAG_W-1:0] out_tag_q, out_tag_d;
    logic [XLEN-1:0]  skid_imm_q, skid_imm_d;
    logic [TAG_W-1:0] skid_tag_q, skid_tag_d;

    logic [31:0]      imm32;
    logic [XLEN-1:0]  dec_imm;
    logic             accept;
    logic             consume;

    // The opcode field never contributes to an immediate.
    logic unused_opcode;
    assign unused_opcode = ^in_inst[6:0];

    // -----------------------------------------------------------------------------------------
    // Decode
    // -----------------------------------------------------------------------------------------
    // Every format is first formed as a 32-bit value that is already sign-extended where
    // needed. ZIMM, SHAMT and NONE always have bit 31 clear. Because of that, one uniform
    // sign-extension from bit 31 gives the correct XLEN result for all eight formats.
    always_comb begin
        imm32 = '0;
        unique case (in_fmt)
            FmtI: begin
                imm32 = {{20{in_inst[31]}}, in_inst[31:20]};
            end
            FmtS: begin
                imm32 = {{20{in_inst[31]}}, in_inst[31:25], in_inst[11:7]};
            end
            FmtB: begin
                imm32 = {{19{in_inst[31]}}, in_inst[31], in_inst[7], in_inst[30:25],
                         in_inst[11:8], 1'b0};
            end
            FmtU: begin
                imm32 = {in_inst[31:12], 12'b0};
            end
            FmtJ: begin
                imm32 = {{11{in_inst[31]}}, in_inst[31], in_inst[19:12], in_inst[20],
                         in_inst[30:21], 1'b0};
            end
            FmtZimm: begin
                imm32 = {27'b0, in_inst[19:15]};
            end
            FmtShamt: begin
                // RV64 shift amounts use one more bit than RV32.
                if (XLEN > 32) begin
                    imm32 = {26'b0, in_inst[25:20]};
                end else begin
                    imm32 = {27'b0, in_inst[24:20]};
                end
            end
            default: begin
                imm32 = '0;
            end
        endcase
    end

    if (XLEN > 32) begin : g_sext
        assign dec_imm = {{(XLEN-32){imm32[31]}}, imm32};
    end else begin : g_nosext
        assign dec_imm = imm32[XLEN-1:0];
    end

    // -----------------------------------------------------------------------------------------
    // Handshake
    // -----------------------------------------------------------------------------------------
    // Both signals are decoded from the state register only.
    assign in_ready  = (state_q != StFull);
    assign out_valid = (state_q != StEmpty);
    assign out_imm   = out_imm_q;
    assign out_tag   = out_tag_q;

    assign accept  = in_valid & in_ready;
    assign consume = out_valid & out_ready;

    // -----------------------------------------------------------------------------------------
    // Next state and datapath
    // -----------------------------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        out_imm_d  = out_imm_q;
        out_tag_d  = out_tag_q;
        skid_imm_d = skid_imm_q;
        skid_tag_d = skid_tag_q;

        if (flush) begin
            // Drop everything, including a beat accepted in this cycle.
            state_d = StEmpty;
        end else begin
            unique case (state_q)
                StEmpty: begin
                    if (accept) begin
                        state_d   = StOne;
                        out_imm_d = dec_imm;
                        out_tag_d = in_tag;
                    end
                end
                StOne: begin
                    if (accept && consume) begin
                        out_imm_d = dec_imm;
                        out_tag_d = in_tag;
                    end else if (accept) begin
                        // The output entry is stalled, so park the new beat in skid.
                        state_d    = StFull;
                        skid_imm_d = dec_imm;
                        skid_tag_d = in_tag;
                    end else if (consume) begin
                        state_d = StEmpty;
                    end
                end
                StFull: begin
                    // in_ready is low here, so the only possible event is a consume.
                    if (consume) begin
                        state_d   = StOne;
                        out_imm_d = skid_imm_q;
                        out_tag_d = skid_tag_q;
                    end
                end
                default: begin
                    state_d = StEmpty;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= StEmpty;
            out_imm_q  <= '0;
            out_tag_q  <= '0;
            skid_imm_q <= '0;
            skid_tag_q <= '0;
        end else begin
            state_q    <= state_d;
            out_imm_q  <= out_imm_d;
            out_tag_q  <= out_tag_d;
            skid_imm_q <= skid_imm_d;
            skid_tag_q <= skid_tag_d;
        end
    end

endmodule

// File: tb/tb_imm_gen_stage.sv
// ---------------------------------------------------------------------------------------------
// tb_imm_gen_stage
//
// Two instances share every input: one built with XLEN=32 and one with XLEN=64. The expected
// stage contents are modelled as a bounded queue that holds at most two beats. Immediates are
// computed from the instruction field values with plain integer arithmetic.
// ---------------------------------------------------------------------------------------------
module tb_imm_gen_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic        out_ready;
    logic [31:0] in_inst;
    logic [2:0]  in_fmt;
    logic [7:0]  in_tag;

    logic        in_ready32, out_valid32;
    logic [31:0] out_imm32;
    logic [7:0]  out_tag32;
    logic        in_ready64, out_valid64;
    logic [63:0] out_imm64;
    logic [7:0]  out_tag64;

    always #5 clk = ~clk;

    imm_gen_stage #(.XLEN(32), .TAG_W(8)) dut32 (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready32),
        .in_inst   (in_inst),
        .in_fmt    (in_fmt),
        .in_tag    (in_tag),
        .out_valid (out_valid32),
        .out_ready (out_ready),
        .out_imm   (out_imm32),
        .out_tag   (out_tag32)
    );

    imm_gen_stage #(.XLEN(64), .TAG_W(8)) dut64 (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready64),
        .in_inst   (in_inst),
        .in_fmt    (in_fmt),
        .in_tag    (in_tag),
        .out_valid (out_valid64),
        .out_ready (out_ready),
        .out_imm   (out_imm64),
        .out_tag   (out_tag64)
    );

    typedef struct {
        logic [31:0] inst;
        logic [2:0]  fmt;
        logic [7:0]  tag;
        logic [31:0] exp32;
        logic [63:0] exp64;
    } vec_t;

    typedef struct {
        logic [31:0] inst;
        logic [2:0]  fmt;
        logic [7:0]  tag;
    } beat_t;

    int    vectors    = 0;
    int    miscompares = 0;
    beat_t q[$];
    bit    just_reset = 1'b0;

    // Immediate value from instruction fields; bits is the signed width of the raw field.
    function automatic logic [63:0] ref_imm(input logic [31:0] inst, input logic [2:0] fmt,
                                            input int xlen);
        longint      raw;
        int          bits;
        logic [63:0] v;
        raw  = 0;
        bits = 0;
        case (fmt)
            3'd0: begin raw = longint'(inst[31:20]); bits = 12; end
            3'd1: begin raw = longint'(inst[31:25]) * 32 + longint'(inst[11:7]); bits = 12; end
            3'd2: begin
                raw  = longint'(inst[31]) * 4096 + longint'(inst[7]) * 2048
                     + longint'(inst[30:25]) * 32 + longint'(inst[11:8]) * 2;
                bits = 13;
            end
            3'd3: begin raw = longint'(inst[31:12]) * 4096; bits = 32; end
            3'd4: begin
                raw  = longint'(inst[31]) * 1048576 + longint'(inst[19:12]) * 4096
                     + longint'(inst[20]) * 2048 + longint'(inst[30:21]) * 2;
                bits = 21;
            end
            3'd5: raw = longint'(inst[19:15]);
            3'd6: raw = (xlen == 64) ? longint'(inst[25:20]) : longint'(inst[24:20]);
            default: raw = 0;
        endcase
        if (bits != 0 && raw >= (64'sd1 <<< (bits - 1))) raw = raw - (64'sd1 <<< bits);
        v = raw;
        if (xlen == 32) v = v & 64'h0000_0000_FFFF_FFFF;
        return v;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_outputs();
        int n;
        n = q.size();
        chk("in_ready32", 64'(in_ready32), 64'(n < 2));
        chk("in_ready64", 64'(in_ready64), 64'(n < 2));
        chk("out_valid32", 64'(out_valid32), 64'(n > 0));
        chk("out_valid64", 64'(out_valid64), 64'(n > 0));
        if (n > 0) begin
            chk("out_imm32", 64'(out_imm32), ref_imm(q[0].inst, q[0].fmt, 32));
            chk("out_imm64", out_imm64, ref_imm(q[0].inst, q[0].fmt, 64));
            chk("out_tag32", 64'(out_tag32), 64'(q[0].tag));
            chk("out_tag64", 64'(out_tag64), 64'(q[0].tag));
        end else if (just_reset) begin
            chk("rst_imm32", 64'(out_imm32), 64'd0);
            chk("rst_imm64", out_imm64, 64'd0);
            chk("rst_tag32", 64'(out_tag32), 64'd0);
            chk("rst_tag64", 64'(out_tag64), 64'd0);
        end
    endtask

    // Apply the inputs currently driven for one clock, update the model, then check.
    task automatic tick();
        int    n;
        bit    acc, con;
        beat_t b;
        n = q.size();
        just_reset = !rst_n;
        if (!rst_n || flush) begin
            q.delete();
        end else begin
            acc = in_valid && (n < 2);
            con = out_ready && (n > 0);
            if (con) void'(q.pop_front());
            if (acc) begin
                b.inst = in_inst;
                b.fmt  = in_fmt;
                b.tag  = in_tag;
                q.push_back(b);
            end
        end
        @(posedge clk);
        @(negedge clk);
        check_outputs();
    endtask

    task automatic offer(input logic v, input logic [31:0] inst, input logic [2:0] fmt,
                         input logic [7:0] tag);
        in_valid = v;
        in_inst  = inst;
        in_fmt   = fmt;
        in_tag   = tag;
    endtask

    vec_t table_v[12];

    initial begin
        table_v[0]  = '{32'hFFF00093, 3'd0, 8'h01, 32'hFFFFFFFF, 64'hFFFFFFFF_FFFFFFFF};
        table_v[1]  = '{32'hFE20AE23, 3'd1, 8'h02, 32'hFFFFFFFC, 64'hFFFFFFFF_FFFFFFFC};
        table_v[2]  = '{32'h00000463, 3'd2, 8'h03, 32'h00000008, 64'h00000000_00000008};
        table_v[3]  = '{32'hFFDFF06F, 3'd4, 8'h04, 32'hFFFFFFFC, 64'hFFFFFFFF_FFFFFFFC};
        table_v[4]  = '{32'h800000B7, 3'd3, 8'h05, 32'h80000000, 64'hFFFFFFFF_80000000};
        table_v[5]  = '{32'h03F0D093, 3'd6, 8'h06, 32'h0000001F, 64'h00000000_0000003F};
        table_v[6]  = '{32'h000F8073, 3'd5, 8'h07, 32'h0000001F, 64'h00000000_0000001F};
        table_v[7]  = '{32'hFFFFFFFF, 3'd5, 8'h08, 32'h0000001F, 64'h00000000_0000001F};
        table_v[8]  = '{32'hFFFFFFFF, 3'd7, 8'h09, 32'h00000000, 64'h00000000_00000000};
        table_v[9]  = '{32'h7FF00013, 3'd0, 8'h0A, 32'h000007FF, 64'h00000000_000007FF};
        table_v[10] = '{32'h12345037, 3'd3, 8'h0B, 32'h12345000, 64'h00000000_12345000};
        table_v[11] = '{32'h7E000FE3, 3'd2, 8'h0C, 32'h00000FFE, 64'h00000000_00000FFE};

        rst_n     = 1'b0;
        flush     = 1'b0;
        out_ready = 1'b0;
        offer(1'b0, 32'd0, 3'd0, 8'd0);
        @(negedge clk);
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        chk("post_reset_ready", 64'(in_ready32), 64'd1);

        // Directed decode table: one beat each, visible one cycle after acceptance.
        for (int i = 0; i < 12; i++) begin
            out_ready = 1'b1;
            offer(1'b1, table_v[i].inst, table_v[i].fmt, table_v[i].tag);
            tick();
            chk("tbl_valid", 64'(out_valid32), 64'd1);
            chk("tbl_imm32", 64'(out_imm32), 64'(table_v[i].exp32));
            chk("tbl_imm64", out_imm64, table_v[i].exp64);
            chk("tbl_tag", 64'(out_tag64), 64'(table_v[i].tag));
            offer(1'b0, 32'd0, 3'd7, 8'd0);
            tick();
        end

        // Backpressure: tags 1,2,3 with the output stalled.
        out_ready = 1'b0;
        offer(1'b1, 32'hFFF00093, 3'd0, 8'd1);
        tick();
        offer(1'b1, 32'hFE20AE23, 3'd1, 8'd2);
        tick();
        offer(1'b1, 32'h00000463, 3'd2, 8'd3);
        tick();
        chk("bp_hold_tag", 64'(out_tag32), 64'd1);
        chk("bp_in_ready", 64'(in_ready64), 64'd0);
        tick();
        chk("bp_still_held", 64'(out_tag64), 64'd1);
        out_ready = 1'b1;
        tick();
        chk("bp_order2", 64'(out_tag32), 64'd2);
        chk("bp_ready_again", 64'(in_ready32), 64'd1);
        tick();
        chk("bp_order3", 64'(out_tag32), 64'd3);
        offer(1'b0, 32'd0, 3'd7, 8'd0);
        tick();
        chk("bp_drained", 64'(out_valid32), 64'd0);

        // Flush while FULL, with a beat offered.
        out_ready = 1'b0;
        offer(1'b1, 32'h800000B7, 3'd3, 8'h10);
        tick();
        offer(1'b1, 32'hFFDFF06F, 3'd4, 8'h11);
        tick();
        flush = 1'b1;
        offer(1'b1, 32'h03F0D093, 3'd6, 8'h12);
        tick();
        chk("fl_valid", 64'(out_valid64), 64'd0);
        chk("fl_ready", 64'(in_ready64), 64'd1);
        // Flush in EMPTY while accepting: the beat is dropped.
        tick();
        chk("fl_drop_acc", 64'(out_valid32), 64'd0);
        flush = 1'b0;
        out_ready = 1'b1;
        offer(1'b0, 32'd0, 3'd7, 8'd0);
        for (int i = 0; i < 3; i++) tick();

        // Reset while FULL, with flush and accept also active.
        out_ready = 1'b0;
        offer(1'b1, 32'hFFF00093, 3'd0, 8'h20);
        tick();
        offer(1'b1, 32'hFE20AE23, 3'd1, 8'h21);
        tick();
        rst_n = 1'b0;
        flush = 1'b1;
        offer(1'b1, 32'h00000463, 3'd2, 8'h22);
        tick();
        chk("rs_valid", 64'(out_valid32), 64'd0);
        chk("rs_ready", 64'(in_ready32), 64'd1);
        rst_n = 1'b1;
        flush = 1'b0;
        out_ready = 1'b1;
        offer(1'b0, 32'd0, 3'd7, 8'd0);
        for (int i = 0; i < 3; i++) tick();

        // Sustained traffic: a new beat every cycle, no bubbles.
        out_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            offer(1'b1, $urandom, 3'($urandom_range(0, 7)), 8'(i + 8'h40));
            tick();
            chk("stream_valid", 64'(out_valid64), 64'd1);
            chk("stream_tag", 64'(out_tag64), 64'(i + 8'h40));
        end
        offer(1'b0, 32'd0, 3'd7, 8'd0);
        tick();

        // Random traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            rst_n     = ($urandom_range(0, 99) != 0);
            flush     = ($urandom_range(0, 49) == 0);
            out_ready = ($urandom_range(0, 3) != 0);
            offer($urandom_range(0, 3) != 0, $urandom, 3'($urandom_range(0, 7)),
                  8'($urandom_range(0, 255)));
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/imm_gen_stage.md
IMM_GEN_STAGE -- requirements
Module: imm_gen_stage

Interface
REQ-001 The block SHALL have parameter XLEN, default 32, meaning datapath width; legal values are 32 and 64.
REQ-002 The block SHALL have parameter TAG_W, default 8, meaning the width of the sideband tag carried with each beat.
REQ-003 The block SHALL have port clk  input  1  meaning the single clock; all state updates occur on its rising edge.
REQ-004 The block SHALL have port rst_n  input  1  meaning reset, synchronous and active-low.
REQ-005 The block SHALL have port flush  input  1  meaning a synchronous discard of all held beats.
REQ-006 The block SHALL have port in_valid  input  1  meaning the upstream beat is valid.
REQ-007 The block SHALL have port in_ready  output  1  meaning the block can accept a beat.
REQ-008 The block SHALL have port in_inst  input  32  meaning the raw instruction word.
REQ-009 The block SHALL have port in_fmt  input  3  meaning the format select: 0=I, 1=S, 2=B, 3=U, 4=J, 5=ZIMM, 6=SHAMT, 7=NONE.
REQ-010 The block SHALL have port in_tag  input  TAG_W  meaning the sideband tag, passed through unchanged.
REQ-011 The block SHALL have port out_valid  output  1  meaning the output beat is valid.
REQ-012 The block SHALL have port out_ready  input  1  meaning downstream accepts the output beat.
REQ-013 The block SHALL have port out_imm  output  XLEN  meaning the decoded immediate.
REQ-014 The block SHALL have port out_tag  output  TAG_W  meaning the tag of the output beat.

Function
REQ-015 Decode: I SHALL be inst[31:20] sign-extended from inst[31] to XLEN.
REQ-016 Decode: S SHALL be {inst[31:25],inst[11:7]} sign-extended to XLEN.
REQ-017 Decode: B SHALL be {inst[31],inst[7],inst[30:25],inst[11:8],0} sign-extended to XLEN.
REQ-018 Decode: U SHALL be {inst[31:12],12'b0} sign-extended from bit 31 to XLEN.
REQ-019 Decode: J SHALL be {inst[31],inst[19:12],inst[20],inst[30:21],0} sign-extended to XLEN.
REQ-020 Decode: ZIMM SHALL be inst[19:15] zero-extended to XLEN.
REQ-021 Decode: SHAMT SHALL be inst[24:20] zero-extended when XLEN=32, and inst[25:20] zero-extended when XLEN=64.
REQ-022 Decode: NONE SHALL produce all zeros.
REQ-023 Decode SHALL occur on the input side, and registered out_imm/out_tag SHALL be stable while out_valid=1 and out_ready=0.
REQ-024 Storage SHALL be two entries: an output register (OUT) and a skid register (SKID), with state EMPTY, ONE (OUT valid), or FULL (OUT and SKID valid).
REQ-025 in_ready SHALL equal !SKID_valid, driven from a register with no combinational path from out_ready.
REQ-026 An input beat SHALL be accepted when in_valid and in_ready are both 1; an output beat SHALL be consumed when out_valid and out_ready are both 1.
REQ-027 Latency SHALL be 1 cycle: a beat accepted in cycle N appears on out_* in cycle N+1 when OUT was empty or consumed in cycle N.
REQ-028 EMPTY plus accept SHALL move to ONE.
REQ-029 ONE with accept and consume SHALL stay in ONE with OUT loaded with the new beat.
REQ-030 ONE with accept and no consume SHALL move to FULL, with the new beat written to SKID.
REQ-031 ONE with consume and no accept SHALL move to EMPTY.
REQ-032 FULL with consume SHALL move to ONE with SKID moved into OUT; no accept is possible in FULL.
REQ-033 Sustained in_valid=1 and out_ready=1 SHALL give a throughput of 1 beat per cycle with no bubbles.
REQ-034 Beat order SHALL be preserved, and no beat SHALL be duplicated or dropped except by flush.
REQ-035 flush=1 SHALL clear OUT_valid and SKID_valid at the next edge, discarding any beat accepted in the same cycle; flush has priority over accept.
REQ-036 out_valid SHALL NOT depend combinationally on in_valid.

Reset
REQ-037 While rst_n=0 at a rising edge, the block SHALL clear OUT_valid and SKID_valid, and SHALL set out_imm and out_tag to 0.
REQ-038 After reset, out_valid SHALL be 0 and in_ready SHALL be 1 from the first cycle with rst_n=1.
REQ-039 Reset asserted mid-transfer SHALL discard all held beats, and reset SHALL take priority over flush and accept.

Verification
REQ-040 Directed: I-format, in_inst=0xFFF00093, XLEN=32 -> out_imm=0xFFFFFFFF one cycle later.
REQ-041 Directed: S-format 0xFE20AE23 -> out_imm=0xFFFFFFFC; B-format 0x00000463 -> out_imm=0x00000008.
REQ-042 Directed: J-format 0xFFDFF06F -> out_imm=0xFFFFFFFC; U-format 0x800000B7 at XLEN=64 -> out_imm=0xFFFFFFFF80000000.
REQ-043 Directed: SHAMT-format 0x03F0D093 at XLEN=64 -> out_imm=0x3F, and at XLEN=32 -> out_imm=0x1F.
REQ-044 Directed backpressure: out_ready=0 with tags 1,2,3 offered back-to-back -> tags 1 and 2 held, in_ready=0; then out_ready=1 -> tags emerge in order 1,2,3 with no loss.
REQ-045 Directed flush and reset: flush or rst_n=0 while FULL -> next cycle out_valid=0 and in_ready=1, and the old tags never appear at the output.
